// File: rtl/barrel_feed_queue_pkg.sv
// Shared widths and the {x, amt} pair layout used by the feed queue and its FIFO.
package barrel_feed_queue_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int PAIR_W  = DATA_W + SHAMT_W;

  typedef struct packed {
    logic [DATA_W-1:0]  x;
    logic [SHAMT_W-1:0] amt;
  } pair_t;

  function automatic pair_t pack_pair(input logic [DATA_W-1:0] x,
                                      input logic [SHAMT_W-1:0] amt);
    pair_t p;
    p.x   = x;
    p.amt = amt;
    return p;
  endfunction

endpackage

// File: rtl/barrel_pair_fifo.sv
// Small power-of-two FIFO holding packed operand pairs; head is read combinationally.
module barrel_pair_fifo
  import barrel_feed_queue_pkg::*;
#(
  parameter int W      = PAIR_W,
  parameter int DEPTH  = barrel_feed_queue_pkg::DEPTH,
  parameter int ADDR_W = barrel_feed_queue_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    wdata,
  output logic [W-1:0]    rdata,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Empty head reads as zero so the shifter sees a quiet operand pair.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/barrel_feed_queue.sv
// Operand feeder for the external barrel shifter: FIFO of (x, amt) pairs plus a
// registered result stage with its own valid/ready.
module barrel_feed_queue
  import barrel_feed_queue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_x,
  input  logic [DATA_W-1:0]  in_y,
  output logic [DATA_W-1:0]  sh_x,
  output logic [SHAMT_W-1:0] sh_amt,
  input  logic [DATA_W-1:0]  sh_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [ADDR_W:0]    count
);

  pair_t wr_pair;
  pair_t head;
  logic  push;
  logic  pop;
  logic  full;
  logic  empty;

  // Only the low shift-amount bits of y matter to the shifter.
  logic [DATA_W-SHAMT_W-1:0] unused_y_high;
  assign unused_y_high = in_y[DATA_W-1:SHAMT_W];

  assign wr_pair  = pack_pair(in_x, in_y[SHAMT_W-1:0]);
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = ~empty & (~res_valid | res_ready);

  barrel_pair_fifo #(
    .W      (PAIR_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_pair),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign sh_x   = head.x;
  assign sh_amt = head.amt;

  // Result stage holds its value under back-pressure and refills on every pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_data  <= sh_out;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
